load_store_sequencer: RTL and testbench
=======================================

# load_store_sequencer

Multicycle memory-access controller for the rv32im core: accepts one load or store request from the control unit, carrying the decoded load op, store op, byte address and store data. It drives the word-addressed memory bus with a valid/ready handshake and returns the aligned, sign- or zero-extended load result as a one-cycle response. Misaligned accesses are either split into two word transactions or reported as errors, selected at compile time. It sits between the main control FSM and the shared memory/IO bus.

## Interface
- ADDR_WIDTH, 32, byte-address width; mem_addr low 2 bits are always 0
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE and not in reset; accept = req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_load_op  in  `LOAD_OP_WIDTH  LB/LH/LW/LBU/LHU code; ignored for stores
- req_store_op  in  `STORE_OP_WIDTH  SB/SH/SW code; ignored for loads
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data, LSB-justified
- mem_valid  out  1  bus request, held until mem_ready
- mem_ready  in  1  bus completion, sampled while mem_valid=1
- mem_addr  out  ADDR_WIDTH  word-aligned address
- mem_wdata  out  32  lane-shifted store data
- mem_wstrb  out  4  byte enables; 4'b0000 = read
- mem_rdata  in  32  read data, valid when mem_valid && mem_ready
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load result; 0 for stores and errors
- rsp_err  out  1  illegal op or unsupported misalignment, valid with rsp_valid

## Operation
- States: IDLE, ACC0, ACC1, RESP.
- IDLE: on accept, register all request fields, then classify.
  - Illegal op code, meaning not one of the five load or three store defines: go to RESP with rsp_err=1. No bus cycle.
  - Otherwise go to ACC0.
- ACC0: mem_valid=1 with mem_addr = {addr[ADDR_WIDTH-1:2],2'b00}.
  - Store: mem_wdata = wdata << (8*addr[1:0]); mem_wstrb = op lane mask (SB 0001, SH 0011, SW 1111) << addr[1:0], truncated to 4 bits.
  - Load: mem_wstrb = 0.
  - On mem_ready: latch mem_rdata into word0. If the access crosses the word (LH/LHU/SH at offset 3; LW/SW at offset ≠0), go to ACC1; else go to RESP.
- ACC1: mem_valid=1 with mem_addr = previous word + 4.
  - Store: remaining high bytes placed from lane 0; mem_wstrb = the lanes spilled past byte 3.
  - On mem_ready: latch word1, go to RESP.
- RESP: rsp_valid=1 for exactly one cycle.
  - Load result = byte/half/word assembled from {word1,word0} >> (8*addr[1:0]).
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Then go to IDLE.
- mem_addr/mem_wdata/mem_wstrb are registered and stable while mem_valid=1. They are 0 outside ACC0/ACC1.
- Address arithmetic wraps modulo 2^ADDR_WIDTH: word 0xFFFFFFFC + 4 → 0x00000000.
- Reset at any state: next cycle state=IDLE and the in-flight bus cycle is abandoned. The bus must tolerate mem_valid dropping.
- Reset values: mem_valid 0, mem_addr 0, mem_wdata 0, mem_wstrb 0, rsp_valid 0, rsp_rdata 0, rsp_err 0. req_ready is 0 while reset is high and 1 the cycle after.

## Timing
- Accept at cycle T → mem_valid from T+1.
- Aligned access, zero wait: mem_ready at T+1 → rsp_valid at T+2 → req_ready at T+3.
- Each wait cycle extends ACC0/ACC1 by one. A split access adds ≥1 cycle.
- Error path: rsp_valid at T+1, no mem_valid.
- No new request is accepted between accept and the cycle after rsp_valid. Throughput is one access per ≥3 cycles.

## Configuration
- `LSU_MISALIGNED_EN` defined: in-word misalignment (e.g. LH at offset 1) is served in one bus cycle; word-crossing accesses are split via ACC1.
- `LSU_MISALIGNED_EN` undefined: ACC1 is not built. Any address not naturally aligned for its size goes to RESP with rsp_err=1, rsp_rdata=0 and no bus cycle.

## Structure
- `STORE_OP_WIDTH` and `STORE_OP_SB/SH/SW` are added to riscv_defines.vh beside the existing LOAD_OP_* defines.
- State encoding stays local to the module.
- One combinational sub-module, load_align_extend: inputs {word1,word0}, offset and load op; output is the extended 32-bit result.

## Test plan
- LW at 0x1000, mem_rdata 0xDEADBEEF, mem_ready at first cycle → rsp_rdata 0xDEADBEEF, rsp_valid at accept+2, mem_wstrb 0000.
- LB at 0x1001, mem_rdata 0x00008000 → 0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at 0x2002, wdata 0x1234ABCD → mem_addr 0x2000, mem_wstrb 1100, mem_wdata 0xABCD0000.
- With `LSU_MISALIGNED_EN`: SW at 0x1002, wdata 0xAABBCCDD → first beat 0x1000/1100/0xCCDD0000, second beat 0x1004/0011/0x0000AABB. LW at 0x1003 with words 0x11223344 and 0x55667788 → 0x66778811.
- Without `LSU_MISALIGNED_EN`: LH at 0x1001 → rsp_err=1 at accept+1, rsp_rdata 0, mem_valid never high.
- Reset asserted while in ACC0 with mem_ready low for 3 cycles → mem_valid 0 and all outputs 0 the next cycle. req_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/load_store_sequencer_pkg.sv
// Shared op codes and size helpers for the load/store sequencer.
// Op encodings follow the rv32im funct3 values for loads and stores.
package load_store_sequencer_pkg;

    localparam int LOAD_OP_WIDTH  = 3;
    localparam int STORE_OP_WIDTH = 2;

    localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LB  = 3'd0;
    localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LH  = 3'd1;
    localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LW  = 3'd2;
    localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LBU = 3'd4;
    localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LHU = 3'd5;

    localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SB = 2'd0;
    localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SH = 2'd1;
    localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SW = 2'd2;

    // Access size in bytes (1/2/4); 0 marks an illegal op code.
    function automatic logic [2:0] access_bytes(
        input logic                      we,
        input logic [LOAD_OP_WIDTH-1:0]  load_op,
        input logic [STORE_OP_WIDTH-1:0] store_op
    );
        access_bytes = 3'd0;
        if (we) begin
            case (store_op)
                STORE_OP_SB: access_bytes = 3'd1;
                STORE_OP_SH: access_bytes = 3'd2;
                STORE_OP_SW: access_bytes = 3'd4;
                default:     access_bytes = 3'd0;
            endcase
        end else begin
            case (load_op)
                LOAD_OP_LB, LOAD_OP_LBU: access_bytes = 3'd1;
                LOAD_OP_LH, LOAD_OP_LHU: access_bytes = 3'd2;
                LOAD_OP_LW:              access_bytes = 3'd4;
                default:                 access_bytes = 3'd0;
            endcase
        end
    endfunction

    function automatic logic [3:0] size_mask(input logic [2:0] bytes);
        case (bytes)
            3'd1:    size_mask = 4'b0001;
            3'd2:    size_mask = 4'b0011;
            3'd4:    size_mask = 4'b1111;
            default: size_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/load_store_sequencer_align.sv
// load_align_extend: picks the addressed byte/half/word out of a two-word
// window and sign- or zero-extends it according to the load op.
module load_align_extend
    import load_store_sequencer_pkg::*;
(
    input  logic [31:0]              word1_i,
    input  logic [31:0]              word0_i,
    input  logic [1:0]               offset_i,
    input  logic [LOAD_OP_WIDTH-1:0] load_op_i,
    output logic [31:0]              result_o
);

    logic [31:0] shifted;

    assign shifted = 32'({word1_i, word0_i} >> {offset_i, 3'b000});

    always_comb begin
        result_o = '0;
        case (load_op_i)
            LOAD_OP_LB:  result_o = {{24{shifted[7]}}, shifted[7:0]};
            LOAD_OP_LBU: result_o = {24'd0, shifted[7:0]};
            LOAD_OP_LH:  result_o = {{16{shifted[15]}}, shifted[15:0]};
            LOAD_OP_LHU: result_o = {16'd0, shifted[15:0]};
            LOAD_OP_LW:  result_o = shifted;
            default:     result_o = '0;
        endcase
    end

endmodule

// File: rtl/load_store_sequencer.sv
// Multicycle load/store sequencer between the control FSM and the memory bus.
// Define LSU_MISALIGNED_EN to split word-crossing accesses; otherwise they error.
module load_store_sequencer
    import load_store_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [LOAD_OP_WIDTH-1:0]  req_load_op,
    input  logic [STORE_OP_WIDTH-1:0] req_store_op,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [31:0]               req_wdata,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [31:0]               mem_wdata,
    output logic [3:0]                mem_wstrb,
    input  logic [31:0]               mem_rdata,
    output logic                      rsp_valid,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_err
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_e;

    state_e                   state_q, state_d;
    logic                     we_q, we_d;
    logic [LOAD_OP_WIDTH-1:0] load_op_q, load_op_d;
    logic [1:0]               off_q, off_d;
    logic                     err_q, err_d;
    logic [31:0]              word0_q, word0_d;
    logic [31:0]              word1_q, word1_d;
    logic [ADDR_WIDTH-1:0]    mem_addr_q, mem_addr_d;
    logic [31:0]              mem_wdata_q, mem_wdata_d;
    logic [3:0]               mem_wstrb_q, mem_wstrb_d;

    logic [2:0]  req_bytes;
    logic [3:0]  req_mask;
    logic [1:0]  req_off;
    logic        req_err;
    logic [31:0] load_result;

    assign req_bytes = access_bytes(req_we, req_load_op, req_store_op);
    assign req_mask  = size_mask(req_bytes);
    assign req_off   = req_addr[1:0];

`ifdef LSU_MISALIGNED_EN
    logic        cross_q, cross_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mask_q, mask_d;
    logic [3:0]  req_end;
    logic [31:0] hi_wdata;
    logic [3:0]  hi_wstrb;

    assign req_end  = {2'b00, req_off} + {1'b0, req_bytes};
    assign req_err  = (req_bytes == 3'd0);
    // Second beat carries the bytes and lanes that spilled past byte 3.
    assign hi_wdata = wdata_q >> (6'd32 - {1'b0, off_q, 3'b000});
    assign hi_wstrb = mask_q >> (3'd4 - {1'b0, off_q});
`else
    assign req_err = (req_bytes == 3'd0)
                   || ((req_bytes == 3'd2) && req_off[0])
                   || ((req_bytes == 3'd4) && (req_off != 2'd0));
`endif

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        load_op_d   = load_op_q;
        off_d       = off_q;
        err_d       = err_q;
        word0_d     = word0_q;
        word1_d     = word1_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
`ifdef LSU_MISALIGNED_EN
        cross_d     = cross_q;
        wdata_d     = wdata_q;
        mask_d      = mask_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d      = req_we;
                    load_op_d = req_load_op;
                    off_d     = req_off;
                    err_d     = req_err;
                    word0_d   = '0;
                    word1_d   = '0;
`ifdef LSU_MISALIGNED_EN
                    cross_d   = (req_end > 4'd4);
                    wdata_d   = req_wdata;
                    mask_d    = req_mask;
`endif
                    if (req_err) begin
                        state_d = RESP;
                    end else begin
                        state_d     = ACC0;
                        mem_addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_wdata_d = req_we ? (req_wdata << {req_off, 3'b000}) : '0;
                        mem_wstrb_d = req_we ? (req_mask << req_off) : '0;
                    end
                end
            end
            ACC0: begin
                if (mem_ready) begin
                    word0_d = mem_rdata;
`ifdef LSU_MISALIGNED_EN
                    if (cross_q) begin
                        state_d     = ACC1;
                        mem_addr_d  = mem_addr_q + ADDR_WIDTH'(4);
                        mem_wdata_d = we_q ? hi_wdata : '0;
                        mem_wstrb_d = we_q ? hi_wstrb : '0;
                    end else begin
                        state_d     = RESP;
                        mem_addr_d  = '0;
                        mem_wdata_d = '0;
                        mem_wstrb_d = '0;
                    end
`else
                    state_d     = RESP;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    mem_wstrb_d = '0;
`endif
                end
            end
            ACC1: begin
`ifdef LSU_MISALIGNED_EN
                if (mem_ready) begin
                    word1_d     = mem_rdata;
                    state_d     = RESP;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    mem_wstrb_d = '0;
                end
`else
                state_d = IDLE;
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            load_op_q   <= '0;
            off_q       <= '0;
            err_q       <= 1'b0;
            word0_q     <= '0;
            word1_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
`ifdef LSU_MISALIGNED_EN
            cross_q     <= 1'b0;
            wdata_q     <= '0;
            mask_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            load_op_q   <= load_op_d;
            off_q       <= off_d;
            err_q       <= err_d;
            word0_q     <= word0_d;
            word1_q     <= word1_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
`ifdef LSU_MISALIGNED_EN
            cross_q     <= cross_d;
            wdata_q     <= wdata_d;
            mask_q      <= mask_d;
`endif
        end
    end

    load_align_extend u_align (
        .word1_i   (word1_q),
        .word0_i   (word0_q),
        .offset_i  (off_q),
        .load_op_i (load_op_q),
        .result_o  (load_result)
    );

    // Handshake: a request is taken when req_valid && req_ready; the bus beat
    // completes when mem_valid && mem_ready; rsp_valid is a single-cycle pulse.
    assign req_ready = (state_q == IDLE) && !reset;
    assign mem_valid = (state_q == ACC0) || (state_q == ACC1);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = (state_q == RESP) && err_q;
    assign rsp_rdata = ((state_q == RESP) && !err_q && !we_q) ? load_result : '0;

endmodule

// File: tb/tb_load_store_sequencer.sv
// Directed table-driven bench for load_store_sequencer; vectors adapt to
// whether LSU_MISALIGNED_EN is defined.
module tb_load_store_sequencer;
    import load_store_sequencer_pkg::*;

    logic                      clk;
    logic                      reset;
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_we;
    logic [LOAD_OP_WIDTH-1:0]  req_load_op;
    logic [STORE_OP_WIDTH-1:0] req_store_op;
    logic [31:0]               req_addr;
    logic [31:0]               req_wdata;
    logic                      mem_valid;
    logic                      mem_ready;
    logic [31:0]               mem_addr;
    logic [31:0]               mem_wdata;
    logic [3:0]                mem_wstrb;
    logic [31:0]               mem_rdata;
    logic                      rsp_valid;
    logic [31:0]               rsp_rdata;
    logic                      rsp_err;

    load_store_sequencer #(.ADDR_WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_load_op  (req_load_op),
        .req_store_op (req_store_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_rdata    (mem_rdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  lop;
        logic [1:0]  sop;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          wait_n;
        int          beats;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] a0;
        logic [3:0]  s0;
        logic [31:0] d0;
        logic [31:0] a1;
        logic [3:0]  s1;
        logic [31:0] d1;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    function automatic vec_t mk(
        input string nm, input logic we, input logic [2:0] lop, input logic [1:0] sop,
        input logic [31:0] addr, input logic [31:0] wdata, input int wait_n, input int beats,
        input logic [31:0] w0, input logic [31:0] w1,
        input logic [31:0] a0, input logic [3:0] s0, input logic [31:0] d0,
        input logic [31:0] a1, input logic [3:0] s1, input logic [31:0] d1,
        input logic [31:0] rdata, input logic err
    );
        vec_t v;
        v.name = nm; v.we = we; v.lop = lop; v.sop = sop; v.addr = addr; v.wdata = wdata;
        v.wait_n = wait_n; v.beats = beats; v.w0 = w0; v.w1 = w1;
        v.a0 = a0; v.s0 = s0; v.d0 = d0; v.a1 = a1; v.s1 = s1; v.d1 = d1;
        v.rdata = rdata; v.err = err;
        return v;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge after the response.
    task automatic do_vec(input vec_t v);
        int beats   = 0;
        int waited  = 0;
        int rsp_cyc = 0;
        bit got     = 0;
        req_valid    = 1'b1;
        req_we       = v.we;
        req_load_op  = v.lop;
        req_store_op = v.sop;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        chk({v.name, "_accept_ready"}, 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom();
        req_wdata = $urandom();
        for (int t = 1; t < 40 && !got; t++) begin
            mem_ready = 1'b0;
            mem_rdata = $urandom();
            if (rsp_valid) begin
                got     = 1'b1;
                rsp_cyc = t;
                chk({v.name, "_rdata"}, rsp_rdata, v.rdata);
                chk({v.name, "_err"}, 32'(rsp_err), 32'(v.err));
                chk({v.name, "_rsp_memvalid"}, 32'(mem_valid), 32'd0);
                chk({v.name, "_rsp_wstrb"}, 32'(mem_wstrb), 32'd0);
            end else begin
                chk({v.name, "_busy_ready"}, 32'(req_ready), 32'd0);
                if (mem_valid) begin
                    chk({v.name, "_addr"}, mem_addr, (beats == 0) ? v.a0 : v.a1);
                    chk({v.name, "_wstrb"}, 32'(mem_wstrb), 32'((beats == 0) ? v.s0 : v.s1));
                    chk({v.name, "_wdata"}, mem_wdata, (beats == 0) ? v.d0 : v.d1);
                    if (waited < v.wait_n) begin
                        waited++;
                    end else begin
                        mem_ready = 1'b1;
                        mem_rdata = (beats == 0) ? v.w0 : v.w1;
                        beats++;
                        waited = 0;
                    end
                end
                @(negedge clk);
            end
        end
        mem_ready = 1'b0;
        chk({v.name, "_rsp_seen"}, 32'(got), 32'd1);
        chk({v.name, "_beats"}, 32'(beats), 32'(v.beats));
        chk({v.name, "_latency"}, 32'(rsp_cyc), 32'(1 + v.beats * (1 + v.wait_n)));
        if (got) @(negedge clk);
        chk({v.name, "_pulse_end"}, 32'(rsp_valid), 32'd0);
        chk({v.name, "_ready_after"}, 32'(req_ready), 32'd1);
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, "_mem_valid"}, 32'(mem_valid), 32'd0);
        chk({nm, "_mem_addr"}, mem_addr, 32'd0);
        chk({nm, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({nm, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
        chk({nm, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({nm, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({nm, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({nm, "_req_ready"}, 32'(req_ready), 32'd0);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_load_op = '0; req_store_op = '0;
        req_addr = '0; req_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;

        //           name        we lop         sop          addr          wdata         wt bt w0            w1            a0            s0       d0            a1            s1       d1            rdata         err
        vecs.push_back(mk("lw_al",   0, LOAD_OP_LW,  2'd0,        32'h0000_1000, 32'h0,        0, 1, 32'hDEAD_BEEF, 32'h0,        32'h0000_1000, 4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hDEAD_BEEF, 0));
        vecs.push_back(mk("lb_neg",  0, LOAD_OP_LB,  2'd0,        32'h0000_1001, 32'h0,        0, 1, 32'h0000_8000, 32'h0,        32'h0000_1000, 4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hFFFF_FF80, 0));
        vecs.push_back(mk("lbu",     0, LOAD_OP_LBU, 2'd0,        32'h0000_1001, 32'h0,        0, 1, 32'h0000_8000, 32'h0,        32'h0000_1000, 4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0000_0080, 0));
        vecs.push_back(mk("sh_hi",   1, 3'd0,        STORE_OP_SH, 32'h0000_2002, 32'h1234_ABCD, 0, 1, 32'h0,        32'h0,        32'h0000_2000, 4'b1100, 32'hABCD_0000, 32'h0,        4'b0000, 32'h0,        32'h0,        0));
        vecs.push_back(mk("lw_wait", 0, LOAD_OP_LW,  2'd0,        32'h0000_3004, 32'h0,        2, 1, 32'h8000_0001, 32'h0,        32'h0000_3004, 4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h8000_0001, 0));
        vecs.push_back(mk("lh_neg",  0, LOAD_OP_LH,  2'd0,        32'h0000_1002, 32'h0,        0, 1, 32'h8001_0000, 32'h0,        32'h0000_1000, 4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hFFFF_8001, 0));
        vecs.push_back(mk("lhu",     0, LOAD_OP_LHU, 2'd0,        32'h0000_1002, 32'h0,        1, 1, 32'h8001_0000, 32'h0,        32'h0000_1000, 4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0000_8001, 0));
        vecs.push_back(mk("sb_b3",   1, 3'd0,        STORE_OP_SB, 32'h0000_0003, 32'h1234_56A5, 0, 1, 32'h0,        32'h0,        32'h0000_0000, 4'b1000, 32'hA500_0000, 32'h0,        4'b0000, 32'h0,        32'h0,        0));
        vecs.push_back(mk("sw_al",   1, 3'd0,        STORE_OP_SW, 32'h0000_0010, 32'h0102_0304, 1, 1, 32'h0,        32'h0,        32'h0000_0010, 4'b1111, 32'h0102_0304, 32'h0,        4'b0000, 32'h0,        32'h0,        0));
        vecs.push_back(mk("ill_ld",  0, 3'd3,        2'd0,        32'h0000_0100, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1));
        vecs.push_back(mk("ill_st",  1, 3'd0,        2'd3,        32'h0000_2000, 32'hFFFF_FFFF, 0, 0, 32'h0,        32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1));
        vecs.push_back(mk("lb_top",  0, LOAD_OP_LB,  2'd0,        32'hFFFF_FFFF, 32'h0,        0, 1, 32'h7F00_0000, 32'h0,        32'hFFFF_FFFC, 4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0000_007F, 0));
`ifdef LSU_MISALIGNED_EN
        vecs.push_back(mk("sw_split",1, 3'd0,        STORE_OP_SW, 32'h0000_1002, 32'hAABB_CCDD, 0, 2, 32'h0,        32'h0,        32'h0000_1000, 4'b1100, 32'hCCDD_0000, 32'h0000_1004, 4'b0011, 32'h0000_AABB, 32'h0,        0));
        vecs.push_back(mk("lw_split",0, LOAD_OP_LW,  2'd0,        32'h0000_1003, 32'h0,        0, 2, 32'h1122_3344, 32'h5566_7788, 32'h0000_1000, 4'b0000, 32'h0,        32'h0000_1004, 4'b0000, 32'h0,        32'h6677_8811, 0));
        vecs.push_back(mk("lh_mis",  0, LOAD_OP_LH,  2'd0,        32'h0000_1001, 32'h0,        0, 1, 32'h00AB_CD00, 32'h0,        32'h0000_1000, 4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hFFFF_ABCD, 0));
        vecs.push_back(mk("lhu_wrap",0, LOAD_OP_LHU, 2'd0,        32'hFFFF_FFFF, 32'h0,        1, 2, 32'hAB00_0000, 32'h0000_00CD, 32'hFFFF_FFFC, 4'b0000, 32'h0,        32'h0000_0000, 4'b0000, 32'h0,        32'h0000_CDAB, 0));
`else
        vecs.push_back(mk("lh_mis",  0, LOAD_OP_LH,  2'd0,        32'h0000_1001, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1));
        vecs.push_back(mk("lw_mis",  0, LOAD_OP_LW,  2'd0,        32'h0000_1002, 32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1));
        vecs.push_back(mk("sw_mis",  1, 3'd0,        STORE_OP_SW, 32'h0000_1003, 32'hAABB_CCDD, 0, 0, 32'h0,        32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1));
`endif

        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        chk("reset_release_ready", 32'(req_ready), 32'd1);

        foreach (vecs[i]) do_vec(vecs[i]);

        // Reset while ACC0 is stalled: the bus cycle is dropped next cycle.
        req_valid = 1'b1; req_we = 1'b0; req_load_op = LOAD_OP_LW; req_addr = 32'h0000_4000;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_mem_valid", 32'(mem_valid), 32'd1);
            chk("stall_mem_addr", mem_addr, 32'h0000_4000);
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        chk_outputs_zero("mid_reset");
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", 32'(req_ready), 32'd1);

        do_vec(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
